morse_seq_packer: RTL and testbench
===================================

// Module: morse_seq_packer
// PURPOSE
//  Clocked, parametrised symbol-to-character packer for the Morse translator. Packs a stream of
//  dot/dash symbols from the signal classifier into one 2-bit-per-symbol character code per
//  terminator. Finished characters go into a small output FIFO with a valid/ready handshake for
//  the sequence separator. Adds overflow detection, length reporting and backpressure.
// PARAMETERS
//  MAX_SYMS    5  max symbols per character; EncSeq width = 2*MAX_SYMS
//  FIFO_DEPTH  4  output FIFO entries; power of two, >= 2
//  LEN_W       $clog2(MAX_SYMS+1)  derived, width of SeqLen (localparam)
// PORTS
//  Clk        in   1          system clock; single clock domain
//  Reset      in   1          synchronous, active-high; clears all state
//  Clear      in   1          sync flush of the character being assembled (FIFO untouched)
//  Signals    in   3          000 dot, 001 dash, 010 end-char+word space, 011 end-char, 1xx no-op
//  SigValid   in   1          Signals qualifier
//  SigReady   out  1          packer accepts Signals; transfer = SigValid & SigReady
//  EncSeq     out  2*MAX_SYMS head-entry code; symbol k at bits [2*MAX_SYMS-1-2k -: 2]; unused = 11
//  SeqLen     out  LEN_W      head-entry symbol count, 0..MAX_SYMS
//  SeqSpace   out  1          1: entry terminated by 010 (word space); 0: by 011
//  SeqOvf     out  1          1: symbols beyond MAX_SYMS were dropped from this entry
//  SeqValid   out  1          FIFO non-empty; head entry on EncSeq/SeqLen/SeqSpace/SeqOvf
//  SeqReady   in   1          consumer pop; pop = SeqValid & SeqReady
//  SentFlag   out  1          toggles on every FIFO push (compatible with the separator)
// BEHAVIOUR
//  Reset values: SigReady 1, SeqValid 0, EncSeq all ones, SeqLen 0, SeqSpace 0, SeqOvf 0, SentFlag 0.
//  Assembly state: buf (2*MAX_SYMS, reset all ones), cnt (LEN_W, reset 0), ovf (reset 0).
//  Accepted dot/dash, cnt < MAX_SYMS: buf slot cnt <= Signals[1:0]; cnt++.
//  Accepted dot/dash, cnt == MAX_SYMS: symbol dropped, ovf <= 1, buf/cnt unchanged.
//  Accepted 010: push {buf,cnt,1,ovf}, also when cnt == 0 (pure word gap, len 0, all ones).
//  Accepted 011, cnt > 0: push {buf,cnt,0,ovf}. With cnt == 0: no push, no toggle, ignored.
//  Every push: buf <= all ones, cnt <= 0, ovf <= 0 in the same cycle; SentFlag toggles.
//  Accepted 1xx: no effect on any state.
//  SigReady = ~full, registered from the FIFO count. No push/pop bypass while full.
//  Priority per cycle: Reset > Clear > accepted Signals. Clear resets buf/cnt/ovf and discards
//   that cycle's symbol. Clear does not stop a pop in the same cycle.
//  Latency: terminator accepted at edge N with FIFO empty -> SeqValid = 1 after edge N
//   (visible in cycle N+1).
//  Simultaneous push and pop (not full): both occur; count unchanged; order is preserved.
//  Output is first-word-fall-through. When empty, EncSeq is all ones and SeqLen/Space/Ovf are 0.
//  Pointers wrap modulo FIFO_DEPTH. count width $clog2(FIFO_DEPTH)+1.
//  Reset mid-character or with a non-empty FIFO: all entries and partial state are discarded.
// STRUCTURE
//  Shared header morse_defs.vh: symbol codes SIG_DOT/SIG_DASH/SIG_SPACE/SIG_ENDSEQ,
//   2-bit element codes EL_DOT=00, EL_DASH=01, EL_NONE=11.
//  Sub-module morse_seq_fifo: sync FWFT FIFO, params WIDTH/DEPTH, ports push/pop/full/empty.
//   Entry width = 2*MAX_SYMS + LEN_W + 2.
//  Top level holds the assembly register, the symbol counter and the push logic.
// TESTING (MAX_SYMS=5, FIFO_DEPTH=4)
//  1 dot,dash,dot,010 -> EncSeq 10'b0001001111, SeqLen 3, SeqSpace 1, SeqOvf 0; SentFlag 0->1.
//  2 six dashes then 011 -> EncSeq 10'b0101010101, SeqLen 5, SeqSpace 0, SeqOvf 1.
//  3 SeqReady=0, four 'dot,011' chars -> SigReady 0 after 4th push; 5th symbol held;
//    one pop -> SigReady 1 next cycle; entries pop in order.
//  4 dash,dash,Clear,dot,011 -> EncSeq 10'b0011111111, SeqLen 1.
//    011 on empty buf -> no push. 010 on empty buf -> len 0, all ones, SeqSpace 1.
//  5 Reset asserted with 2 entries queued and 3 symbols pending -> next cycle SeqValid 0,
//    SigReady 1, SentFlag 0. Then dot,010 -> EncSeq 10'b0011111111, SeqLen 1.
//  6 push and pop in the same cycle with 2 entries queued -> count stays 2; FIFO order intact.

Source files
------------

// File: rtl/morse_seq_packer_pkg.sv
// Shared symbol codes, element codes and default sizing for the Morse sequence packer.
package morse_seq_packer_pkg;

  localparam int DEF_MAX_SYMS   = 5;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    SIG_DOT    = 3'b000,
    SIG_DASH   = 3'b001,
    SIG_SPACE  = 3'b010,
    SIG_ENDSEQ = 3'b011
  } sig_e;

  localparam logic [1:0] EL_DOT  = 2'b00;
  localparam logic [1:0] EL_DASH = 2'b01;
  localparam logic [1:0] EL_NONE = 2'b11;

endpackage

// File: rtl/morse_seq_packer_if.sv
// Symbol input channel and packed-character output channel of the packer.
interface morse_seq_packer_if
  import morse_seq_packer_pkg::*;
#(
  parameter int MAX_SYMS = DEF_MAX_SYMS,
  parameter int LEN_W    = $clog2(MAX_SYMS + 1)
);
  logic [2:0]            Signals;
  logic                  SigValid;
  logic                  SigReady;
  logic [2*MAX_SYMS-1:0] EncSeq;
  logic [LEN_W-1:0]      SeqLen;
  logic                  SeqSpace;
  logic                  SeqOvf;
  logic                  SeqValid;
  logic                  SeqReady;
  logic                  SentFlag;

  modport master (
    output Signals, SigValid, SeqReady,
    input  SigReady, EncSeq, SeqLen, SeqSpace, SeqOvf, SeqValid, SentFlag
  );

  modport slave (
    input  Signals, SigValid, SeqReady,
    output SigReady, EncSeq, SeqLen, SeqSpace, SeqOvf, SeqValid, SentFlag
  );
endinterface

// File: rtl/morse_seq_packer_fifo.sv
// Synchronous first-word-fall-through FIFO holding finished character entries.
module morse_seq_packer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Head is read straight from the array so the entry is visible the cycle after its push.
  assign head_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/morse_seq_packer.sv
// Packs dot/dash symbols into 2-bit-per-symbol character codes and queues each finished
// character for the sequence separator behind a valid/ready handshake.
module morse_seq_packer
  import morse_seq_packer_pkg::*;
#(
  parameter int MAX_SYMS   = DEF_MAX_SYMS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clear,
  morse_seq_packer_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_SYMS + 1);
  localparam int BUF_W = 2 * MAX_SYMS;
  localparam int ENT_W = BUF_W + LEN_W + 2;

  logic [BUF_W-1:0] sym_buf_q, sym_buf_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             sent_q;
  logic             accept, push, pop, full, empty;
  logic [ENT_W-1:0] push_data, head_data;
  sig_e             sig;

  assign sig    = sig_e'(bus.Signals);
  assign accept = bus.SigValid & bus.SigReady;
  assign pop    = bus.SeqValid & bus.SeqReady;

  always_comb begin
    sym_buf_d = sym_buf_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    push      = 1'b0;
    if (Clear) begin
      sym_buf_d = {MAX_SYMS{EL_NONE}};
      cnt_d     = '0;
      ovf_d     = 1'b0;
    end else if (accept) begin
      if (sig == SIG_DOT || sig == SIG_DASH) begin
        if (cnt_q < LEN_W'(MAX_SYMS)) begin
          for (int k = 0; k < MAX_SYMS; k++) begin
            if (cnt_q == LEN_W'(k)) sym_buf_d[BUF_W-1-2*k -: 2] = bus.Signals[1:0];
          end
          cnt_d = cnt_q + LEN_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end else if (sig == SIG_SPACE || (sig == SIG_ENDSEQ && cnt_q != '0)) begin
        push = 1'b1;
      end
    end
    // A push hands the current character to the FIFO and starts a fresh one.
    if (push) begin
      sym_buf_d = {MAX_SYMS{EL_NONE}};
      cnt_d     = '0;
      ovf_d     = 1'b0;
    end
  end

  assign push_data = {sym_buf_q, cnt_q, (sig == SIG_SPACE), ovf_q};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sym_buf_q <= {MAX_SYMS{EL_NONE}};
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      sent_q    <= 1'b0;
    end else begin
      sym_buf_q <= sym_buf_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      if (push) sent_q <= ~sent_q;
    end
  end

  morse_seq_packer_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (Clk),
    .srst      (Reset),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .head_data (head_data),
    .full      (full),
    .empty     (empty)
  );

  // An empty FIFO presents the idle code rather than stale array contents.
  assign bus.SigReady = ~full;
  assign bus.SeqValid = ~empty;
  assign bus.EncSeq   = empty ? {MAX_SYMS{EL_NONE}} : head_data[ENT_W-1 -: BUF_W];
  assign bus.SeqLen   = empty ? '0 : head_data[LEN_W+1:2];
  assign bus.SeqSpace = empty ? 1'b0 : head_data[1];
  assign bus.SeqOvf   = empty ? 1'b0 : head_data[0];
  assign bus.SentFlag = sent_q;

endmodule

// File: tb/tb_morse_seq_packer.sv
// Scoreboard bench for morse_seq_packer: directed scenarios followed by randomized traffic.
module tb_morse_seq_packer;
  import morse_seq_packer_pkg::*;

  localparam int MS    = 5;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(MS + 1);

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  logic Clear = 1'b0;

  morse_seq_packer_if #(.MAX_SYMS(MS)) bus ();

  morse_seq_packer #(
    .MAX_SYMS   (MS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Clear (Clear),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [2*MS-1:0] enc;
    logic [LW-1:0]   len;
    logic            space;
    logic            ovf;
  } ent_t;

  // Reference: the character is a list of symbols; finished characters queue up in order.
  ent_t       exp_q[$];
  logic [1:0] syms[$];
  logic       m_ovf    = 1'b0;
  int         fifo_cnt = 0;
  logic       m_sent   = 1'b0;
  int         n_cmp    = 0;
  int         n_bad    = 0;
  ent_t       mon_e;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void emit(input logic space);
    ent_t e;
    e.enc = '1;
    foreach (syms[k]) e.enc[2*MS-1-2*k -: 2] = syms[k];
    e.len   = LW'(syms.size());
    e.space = space;
    e.ovf   = m_ovf;
    exp_q.push_back(e);
    fifo_cnt++;
    m_sent = ~m_sent;
    syms.delete();
    m_ovf = 1'b0;
  endfunction

  // One clock of stimulus; called #1 after a rising edge, returns #1 after the next one.
  task automatic drive(input logic [2:0] s, input logic v, input logic clr,
                       input logic rdy, input logic rst);
    logic acc, popq;
    bus.Signals  = s;
    bus.SigValid = v;
    Clear        = clr;
    bus.SeqReady = rdy;
    Reset        = rst;
    acc  = v & bus.SigReady;
    popq = bus.SeqValid & rdy;
    @(posedge Clk);
    if (rst) begin
      syms.delete();
      exp_q.delete();
      m_ovf    = 1'b0;
      fifo_cnt = 0;
      m_sent   = 1'b0;
    end else begin
      if (popq) fifo_cnt--;
      if (clr) begin
        syms.delete();
        m_ovf = 1'b0;
      end else if (acc) begin
        if (s == SIG_DOT || s == SIG_DASH) begin
          if (syms.size() < MS) syms.push_back(s[1:0]);
          else m_ovf = 1'b1;
        end else if (s == SIG_SPACE) begin
          emit(1'b1);
        end else if (s == SIG_ENDSEQ && syms.size() > 0) begin
          emit(1'b0);
        end
      end
    end
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(3'b100, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic sym(input logic [2:0] s);
    drive(s, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_head(input string nm, input logic [2*MS-1:0] enc, input int len,
                             input logic sp, input logic ov);
    cmp({nm, "_valid"}, 32'(bus.SeqValid), 32'd1);
    cmp({nm, "_enc"},   32'(bus.EncSeq),   32'(enc));
    cmp({nm, "_len"},   32'(bus.SeqLen),   32'(len));
    cmp({nm, "_space"}, 32'(bus.SeqSpace), 32'(sp));
    cmp({nm, "_ovf"},   32'(bus.SeqOvf),   32'(ov));
  endtask

  // Monitor: pops the expected entry whenever the DUT hands one over.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (bus.SeqValid && bus.SeqReady) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pop: got enc=0x%0h len=%0d, expected no entry",
                   bus.EncSeq, bus.SeqLen);
        end else begin
          mon_e = exp_q.pop_front();
          $display("pop enc=%b len=%0d space=%0b ovf=%0b", bus.EncSeq, bus.SeqLen,
                   bus.SeqSpace, bus.SeqOvf);
          cmp("pop_enc",   32'(bus.EncSeq),   32'(mon_e.enc));
          cmp("pop_len",   32'(bus.SeqLen),   32'(mon_e.len));
          cmp("pop_space", 32'(bus.SeqSpace), 32'(mon_e.space));
          cmp("pop_ovf",   32'(bus.SeqOvf),   32'(mon_e.ovf));
        end
      end
      if (!bus.SeqValid) begin
        cmp("idle_enc", 32'(bus.EncSeq), 32'(10'h3FF));
        cmp("idle_len_space_ovf", {29'd0, bus.SeqLen}, 32'd0);
        cmp("idle_space_ovf", {30'd0, bus.SeqSpace, bus.SeqOvf}, 32'd0);
      end
      cmp("sig_ready", 32'(bus.SigReady), 32'(fifo_cnt < DEPTH));
      cmp("seq_valid", 32'(bus.SeqValid), 32'(fifo_cnt != 0));
      cmp("sent_flag", 32'(bus.SentFlag), 32'(m_sent));
    end
  end

  initial begin
    logic [2:0] s;
    int         r, rdy_pct;
    bus.Signals  = 3'b100;
    bus.SigValid = 1'b0;
    bus.SeqReady = 1'b0;
    @(posedge Clk);
    #1;
    drive(3'b100, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(3'b100, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("rst_sigready", 32'(bus.SigReady), 32'd1);
    cmp("rst_seqvalid", 32'(bus.SeqValid), 32'd0);
    cmp("rst_enc",      32'(bus.EncSeq),   32'(10'h3FF));
    cmp("rst_sentflag", 32'(bus.SentFlag), 32'd0);

    // dot,dash,dot,word-space
    sym(SIG_DOT); sym(SIG_DASH); sym(SIG_DOT); sym(SIG_SPACE);
    expect_head("t1", 10'b0001001111, 3, 1'b1, 1'b0);
    cmp("t1_sentflag", 32'(bus.SentFlag), 32'd1);
    idle(1'b1);

    // overflow: six dashes, end-char
    repeat (6) sym(SIG_DASH);
    sym(SIG_ENDSEQ);
    expect_head("t2", 10'b0101010101, 5, 1'b0, 1'b1);
    idle(1'b1);

    // fill with 1..4 dots per character, check backpressure and order
    for (int i = 1; i <= 4; i++) begin
      for (int j = 0; j < i; j++) sym(SIG_DOT);
      sym(SIG_ENDSEQ);
    end
    cmp("t3_full_sigready", 32'(bus.SigReady), 32'd0);
    sym(SIG_DASH);
    cmp("t3_held_sigready", 32'(bus.SigReady), 32'd0);
    idle(1'b1);
    cmp("t3_after_pop_sigready", 32'(bus.SigReady), 32'd1);
    repeat (4) idle(1'b1);

    // Clear mid-character, empty end-char, empty word space
    sym(SIG_DASH); sym(SIG_DASH);
    drive(SIG_DASH, 1'b1, 1'b1, 1'b0, 1'b0);
    sym(SIG_DOT); sym(SIG_ENDSEQ);
    expect_head("t4", 10'b0011111111, 1, 1'b0, 1'b0);
    drive(3'b100, 1'b0, 1'b1, 1'b1, 1'b0);
    cmp("t4_pop_with_clear", 32'(bus.SeqValid), 32'd0);
    sym(SIG_ENDSEQ);
    cmp("t4_empty_endseq", 32'(bus.SeqValid), 32'd0);
    sym(SIG_SPACE);
    expect_head("t4_gap", 10'b1111111111, 0, 1'b1, 1'b0);
    idle(1'b1);

    // reset with queued entries and a pending character
    sym(SIG_DOT); sym(SIG_ENDSEQ); sym(SIG_DASH); sym(SIG_ENDSEQ);
    sym(SIG_DOT); sym(SIG_DASH); sym(SIG_DOT);
    drive(3'b100, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("t5_seqvalid", 32'(bus.SeqValid), 32'd0);
    cmp("t5_sigready", 32'(bus.SigReady), 32'd1);
    cmp("t5_sentflag", 32'(bus.SentFlag), 32'd0);
    sym(SIG_DOT); sym(SIG_SPACE);
    expect_head("t5", 10'b0011111111, 1, 1'b1, 1'b0);
    idle(1'b1);

    // simultaneous push and pop with two entries queued
    sym(SIG_DASH); sym(SIG_ENDSEQ);
    sym(SIG_DOT); sym(SIG_DASH); sym(SIG_ENDSEQ);
    sym(SIG_DOT);
    drive(SIG_SPACE, 1'b1, 1'b0, 1'b1, 1'b0);
    sym(SIG_DASH); sym(SIG_ENDSEQ);
    cmp("t6_one_slot_left", 32'(bus.SigReady), 32'd1);
    sym(SIG_DOT); sym(SIG_ENDSEQ);
    cmp("t6_full", 32'(bus.SigReady), 32'd0);
    repeat (5) idle(1'b1);

    // randomized traffic in phases with different consumer speeds
    for (int ph = 0; ph < 6; ph++) begin
      rdy_pct = (ph % 3 == 0) ? 20 : ((ph % 3 == 1) ? 60 : 95);
      for (int n = 0; n < 500; n++) begin
        r = int'($urandom_range(0, 9));
        if (r <= 3)      s = SIG_DOT;
        else if (r <= 6) s = SIG_DASH;
        else if (r == 7) s = SIG_SPACE;
        else if (r == 8) s = SIG_ENDSEQ;
        else             s = {1'b1, 2'($urandom_range(0, 3))};
        drive(s, ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 99) < rdy_pct), ($urandom_range(0, 299) == 0));
      end
    end
    repeat (DEPTH + 2) idle(1'b1);
    cmp("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
